// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter and sequencer for a shared 4:1 select datapath.
// Four requesters compete for the path. Each grant lasts at most HOLD cycles,
// or less if the owner drops its request. On release the priority pointer
// moves past the owner, and arbitration is redone on the same edge, so
// persistent requesters receive back-to-back grants with no idle cycle.
// The selected word is registered onto dout one cycle behind the grant.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   req       in   4   request per requester, held while the path is wanted
//   din0..3   in   DW  requester data words
//   gnt       out  4   registered one-hot grant, zero when idle
//   sel       out  2   registered index of the current or last grant
//   dout      out  DW  registered muxed data
//   dout_vld  out  1   dout was loaded on a granted cycle
//   busy      out  1   registered, high while a grant is active
module mux_rr_arbiter #(
    parameter int DW   = 3,
    parameter int HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t        state_r, state_s;
    logic [1:0]    ptr_r, ptr_s;
    logic [3:0]    cnt_r, cnt_s;
    logic [3:0]    gnt_r, gnt_s;
    logic [1:0]    sel_r, sel_s;
    logic [DW-1:0] dout_r, dout_s;
    logic          vld_r, vld_s;
    logic          busy_r;

    logic [DW-1:0] mux_s;
    logic [2:0]    pick_idle_s;
    logic [2:0]    pick_rel_s;
    logic [1:0]    rel_base_s;

    // Returns {found, index} of the first set request, searching from base upward mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Selects the data word of the current owner.
    always_comb begin
        mux_s = din0;
        case (sel_r)
            2'd0:    mux_s = din0;
            2'd1:    mux_s = din1;
            2'd2:    mux_s = din2;
            2'd3:    mux_s = din3;
            default: mux_s = din0;
        endcase
    end

    // Two candidate arbitrations: from the pointer when idle, and from past
    // the current owner when a grant is being released.
    always_comb begin
        rel_base_s  = sel_r + 2'd1;
        pick_idle_s = rr_pick(req, ptr_r);
        pick_rel_s  = rr_pick(req, rel_base_s);
    end

    // Next-state, grant, counter and data decisions.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        dout_s  = dout_r;
        vld_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_s = GRANT;
                    gnt_s   = 4'b0001 << pick_idle_s[1:0];
                    sel_s   = pick_idle_s[1:0];
                    cnt_s   = HOLD_M1;
                end else begin
                    state_s = IDLE;
                    gnt_s   = 4'b0000;
                end
            end
            GRANT: begin
                // A cycle whose owner has dropped its request does not update dout.
                if (req[sel_r]) begin
                    dout_s = mux_s;
                    vld_s  = 1'b1;
                end else begin
                    dout_s = dout_r;
                    vld_s  = 1'b0;
                end
                if (!req[sel_r] || (cnt_r == 4'd0)) begin
                    ptr_s = rel_base_s;
                    if (pick_rel_s[2]) begin
                        state_s = GRANT;
                        gnt_s   = 4'b0001 << pick_rel_s[1:0];
                        sel_s   = pick_rel_s[1:0];
                        cnt_s   = HOLD_M1;
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 4'b0000;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 4'b0000;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= 4'd0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            dout_r  <= '0;
            vld_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            dout_r  <= dout_s;
            vld_r   <= vld_s;
            busy_r  <= (state_s == GRANT);
        end
    end

    assign gnt      = gnt_r;
    assign sel      = sel_r;
    assign dout     = dout_r;
    assign dout_vld = vld_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: two instances (HOLD=4 and HOLD=1) share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_mux_rr_arbiter;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] din0, din1, din2, din3;

    logic [3:0]    a_gnt, b_gnt;
    logic [1:0]    a_sel, b_sel;
    logic [DW-1:0] a_dout, b_dout;
    logic          a_vld, b_vld, a_busy, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state per instance (0: HOLD=4, 1: HOLD=1).
    int hold_of[2] = '{4, 1};
    int m_own[2];
    int m_used[2];
    int m_ptr[2];
    int m_sel[2];
    int m_dout[2];
    int m_vld[2];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DW(DW), .HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(a_gnt), .sel(a_sel), .dout(a_dout), .dout_vld(a_vld), .busy(a_busy)
    );

    mux_rr_arbiter #(.DW(DW), .HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(b_gnt), .sel(b_sel), .dout(b_dout), .dout_vld(b_vld), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int base);
        for (int i = 0; i < 4; i++) begin
            if (r[(base + i) % 4]) return (base + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_used[k] = 0;
            m_ptr[k]  = 0;
            m_sel[k]  = 0;
            m_dout[k] = 0;
            m_vld[k]  = 0;
        end
    endtask

    // One rising edge of the abstract arbiter, from the inputs sampled at that edge.
    task automatic model_step();
        logic [DW-1:0] d[4];
        int w;
        bit dropped;
        d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3;
        for (int k = 0; k < 2; k++) begin
            if (m_own[k] < 0) begin
                m_vld[k] = 0;
                if (req != 4'b0000) begin
                    w = pick(req, m_ptr[k]);
                    m_own[k] = w; m_sel[k] = w; m_used[k] = 1;
                end
            end else begin
                dropped = !req[m_own[k]];
                if (!dropped) begin
                    m_dout[k] = int'(d[m_own[k]]);
                    m_vld[k]  = 1;
                end else begin
                    m_vld[k] = 0;
                end
                if (dropped || m_used[k] >= hold_of[k]) begin
                    m_ptr[k] = (m_own[k] + 1) % 4;
                    w = pick(req, m_ptr[k]);
                    if (w >= 0) begin
                        m_own[k] = w; m_sel[k] = w; m_used[k] = 1;
                    end else begin
                        m_own[k] = -1;
                    end
                end else begin
                    m_used[k]++;
                end
            end
        end
    endtask

    task automatic check_one(input string nm, input int k, input logic [3:0] g, input logic [1:0] s,
                             input logic [DW-1:0] d, input logic v, input logic b);
        logic [3:0] eg;
        eg = (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
        check_eq({nm, ".gnt"}, 32'(g), 32'(eg));
        check_eq({nm, ".sel"}, 32'(s), 32'(m_sel[k]));
        check_eq({nm, ".dout"}, 32'(d), 32'(m_dout[k]));
        check_eq({nm, ".dout_vld"}, 32'(v), 32'(m_vld[k]));
        check_eq({nm, ".busy"}, 32'(b), 32'(m_own[k] >= 0));
    endtask

    task automatic check_outputs();
        check_one("h4", 0, a_gnt, a_sel, a_dout, a_vld, a_busy);
        check_one("h1", 1, b_gnt, b_sel, b_dout, b_vld, b_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear with no edge.
    task automatic async_reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single requester with constant data, including sole-requester re-grant.
        din1 = 3'h5;
        req  = 4'b0010;
        repeat (12) tick();

        // Idle gap.
        req = 4'b0000;
        repeat (3) tick();

        // Full rotation among four persistent requesters.
        din0 = 3'h2; din1 = 3'h1; din2 = 3'h3; din3 = 3'h6;
        req  = 4'b1111;
        repeat (12) tick();

        // Early drop by requester 2 while requester 0 waits.
        req = 4'b0000;
        repeat (6) tick();
        req = 4'b0100;
        tick();
        req = 4'b0101;
        tick();
        tick();
        req = 4'b0001;
        repeat (4) tick();

        // Wrap-around: grant to 2 then release leaves the pointer at 3.
        req = 4'b0000;
        repeat (6) tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (2) tick();
        req = 4'b1001;
        repeat (10) tick();

        // Reset in the middle of a grant to requester 2.
        req = 4'b0000;
        repeat (6) tick();
        req = 4'b0100;
        repeat (2) tick();
        check_eq("h4.gnt_before_reset", 32'(a_gnt), 32'h4);
        async_reset_pulse();
        req = 4'b0000;
        repeat (3) tick();

        // Randomized traffic with mostly persistent requests.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 39) == 0) req = 4'b0000;
            din0 = DW'($urandom); din1 = DW'($urandom);
            din2 = DW'($urandom); din3 = DW'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 select datapath (`hw_assign`-class mux). It arbitrates four requesters, each with its own DW-bit data word, and drives the 2-bit select. Each grant lasts for a bounded number of cycles. It also registers the selected data onto a single output with a valid flag. It sits between requesting sources and the downstream consumer of the muxed word, replacing a testbench-driven `sel`.

## Interface
- `DW`, default 3: data width of each input and of `dout`.
- `HOLD`, default 4: maximum consecutive grant cycles per grant, legal range 1..15.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, 4: request per requester; `req[i]` is held high while requester i wants the path.
- `din0`..`din3`, in, DW each: requester data words.
- `gnt`, out, 4: one-hot grant (registered); all zero when idle.
- `sel`, out, 2: index of the current or last grant (registered); it drives the mux select.
- `dout`, out, DW: registered muxed data.
- `dout_vld`, out, 1: `dout` carries data from a granted cycle.
- `busy`, out, 1: high while in GRANT.

## Operation
- Internal state:
  - FSM {IDLE, GRANT}.
  - 2-bit priority pointer `ptr`.
  - 4-bit down-counter `cnt`.
- Arbitration function (combinational): search `req` starting at index `ptr`, then `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The first set bit wins.
- IDLE:
  - If `req != 0`: set `gnt` to one-hot of the winner, set `sel` to the winner, load `cnt = HOLD-1`, and go to GRANT.
  - Otherwise stay in IDLE with `gnt = 0`.
- GRANT, per cycle:
  - `dout <= din[sel]` and `dout_vld <= 1`.
  - A release occurs when `req[sel]==0` or `cnt==0`. Otherwise `cnt <= cnt-1`.
- On release:
  - Set `ptr <= sel+1` (mod 4, so 3 wraps to 0).
  - Re-arbitrate in the same edge using the new pointer over the current `req`.
  - If there is a winner: grant it immediately (back-to-back, no idle cycle) and reload `cnt = HOLD-1`. The previous owner may win again only if it is the sole requester.
  - If there is no winner: go to IDLE with `gnt <= 0`. `sel` keeps its last value.
- `busy` = (state == GRANT).
- In IDLE, `dout_vld <= 0` and `dout` holds its last value.
- Only one `gnt` bit is ever high.
- `ptr` changes only on release. An IDLE→GRANT transition does not move `ptr`.
- `HOLD=1`: every grant lasts exactly one cycle, which gives strict rotation among persistent requesters.

## Timing
- Reset values, applied asynchronously and immediately, including mid-grant:
  - `gnt=0`, `sel=0`, `dout=0`, `dout_vld=0`, `busy=0`.
  - `ptr=0`, `cnt=0`, state IDLE.
- After deassertion, the first arbitration happens at the first rising edge at which `req != 0`.
- Grant latency: when `req` is first sampled high at edge N, `gnt`/`sel` are valid after edge N.
- Data latency: `dout`/`dout_vld` lag `gnt` by one cycle. The value on `dout` after edge N+1 is `din[sel]` as sampled at edge N+1.
- Grant length:
  - With `req` held, `gnt` is high for exactly HOLD cycles and `dout_vld` for exactly HOLD cycles (shifted by 1).
  - If the owner drops `req`, the grant ends at the first edge that samples `req[sel]=0`. That cycle produces no `dout` update.
- Simultaneous events: when a release and a new request occur at the same edge, the new request participates in the re-arbitration of that edge.
- During back-to-back grants, `dout_vld` stays continuously high across the owner change.

## Test plan
- Reset: assert `rst` mid-grant (with `gnt=4'b0100`) → all outputs 0 with no clock edge needed. After release and with `req=0` → `gnt` stays 0 and `busy` stays 0.
- Single requester, `HOLD=4`: `req=4'b0010`, `din1=3'h5` held → `gnt=4'b0010`, `sel=1` for exactly 4 cycles. `dout=3'h5` with `dout_vld=1` for 4 cycles, one cycle later. Then sole-requester re-grant continues the same pattern with no gap.
- Round-robin rotation: `req=4'b1111`, `din0..din3 = 3'h2, 3'h1, 3'h3, 3'h6`, `HOLD=1` → `sel` sequence 0,1,2,3,0… and `dout` sequence 2,1,3,6,2… with `dout_vld` constantly 1.
- Early drop: requester 2 granted and drops `req` after 2 cycles while `req[0]=1` → `gnt` goes 4'b0100 (2 cycles) then 4'b0001. `ptr` becomes 3, so requester 0 wins via wrap-around.
- Wrap and fairness: `ptr=3` (after a grant to 2), `req=4'b1001` → requester 3 is granted first, then 0.
- Idle gap: after all `req` drop → `gnt=0`, `busy=0`, `dout_vld=0` the next cycle, `dout` holds its last value, and `sel` holds its last index.
